i2c_audio_codec_target: RTL

//  I2C target (slave) that accepts WM8731-style 3-byte register writes: {dev_addr+W, reg[6:0]+data[8], data[7:0]}.

---
 rtl/i2c_audio_codec_target_pkg.sv | 28 ++
 rtl/i2c_audio_codec_target_bus_sync.sv | 45 ++++
 rtl/i2c_audio_codec_target.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/i2c_audio_codec_target_pkg.sv
// Shared constants for the WM8731-style I2C codec target: default address,
// codec register indices and FSM state encodings.
package i2c_audio_codec_target_pkg;

    localparam logic [6:0] DEV_ADDR_DEF = 7'h1A;

    localparam logic [6:0] R_LVOL  = 7'h02;
    localparam logic [6:0] R_RVOL  = 7'h03;
    localparam logic [6:0] R_APATH = 7'h04;
    localparam logic [6:0] R_DPATH = 7'h05;
    localparam logic [6:0] R_PWR   = 7'h06;
    localparam logic [6:0] R_FMT   = 7'h07;
    localparam logic [6:0] R_SAMP  = 7'h08;
    localparam logic [6:0] R_ACT   = 7'h09;
    localparam logic [6:0] R_RESET = 7'h0F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_A,
        S_BYTE1,
        S_ACK_1,
        S_BYTE2,
        S_ACK_2,
        S_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_audio_codec_target_bus_sync.sv
// Synchronises the asynchronous SCL/SDA pins and derives START, STOP and
// SCL edge pulses from the synchronised levels plus one history flop.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall
);

    logic [SYNC_STAGES-1:0] scl_p0;
    logic [SYNC_STAGES-1:0] sda_p0;
    logic                   scl_p1;
    logic                   sda_p1;
    logic                   scl;

    // Idle bus level is high on both lines, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_p0 <= '1;
            sda_p0 <= '1;
            scl_p1 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p0 <= {scl_p0[SYNC_STAGES-2:0], scl_i};
            sda_p0 <= {sda_p0[SYNC_STAGES-2:0], sda_i};
            scl_p1 <= scl_p0[SYNC_STAGES-1];
            sda_p1 <= sda_p0[SYNC_STAGES-1];
        end
    end

    assign scl      = scl_p0[SYNC_STAGES-1];
    assign sda      = sda_p0[SYNC_STAGES-1];
    assign start    = scl & scl_p1 & sda_p1 & ~sda;
    assign stop     = scl & scl_p1 & ~sda_p1 & sda;
    assign scl_rise = scl & ~scl_p1;
    assign scl_fall = ~scl & scl_p1;

endmodule

// File: rtl/i2c_audio_codec_target.sv
// I2C target accepting 3-byte WM8731-style register writes into a 16 x 9-bit
// register file; writes to R_RESET clear the whole file instead of storing.
module i2c_audio_codec_target
    import i2c_audio_codec_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic       addr_err
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic       sda;
    logic       start;
    logic       stop;
    logic       scl_rise;
    logic       scl_fall;

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] sh;
    logic [6:0] reg_q;
    logic       d8;
    logic [8:0] regs [NUM_REGS];
    logic       byte_done;
    logic       commit;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    assign byte_done = scl_fall && (cnt == 4'd8);
    assign commit    = (state == S_BYTE2) && byte_done && (reg_q[6:4] == 3'b000);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            if (reg_q == R_RESET) begin
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            end else begin
                regs[reg_q[IDX_W-1:0]] <= {d8, sh};
            end
        end
    end

    assign rd_data = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sda_oe   <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            addr_err <= 1'b0;
            if (start) begin
                state  <= S_ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b1;
            end else if (stop) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                if (scl_rise && (state == S_ADDR || state == S_BYTE1 || state == S_BYTE2)) begin
                    sh  <= {sh[6:0], sda};
                    cnt <= cnt + 4'd1;
                end
                // Every ACK decision and release happens on the SCL fall, so SDA
                // only ever moves while SCL is low.
                if (scl_fall) begin
                    case (state)
                        S_ADDR: if (byte_done) begin
                            cnt <= '0;
                            if (sh == {DEV_ADDR, 1'b0}) begin
                                state  <= S_ACK_A;
                                sda_oe <= 1'b1;
                            end else begin
                                state    <= S_IGNORE;
                                addr_err <= 1'b1;
                            end
                        end
                        S_ACK_A: begin
                            sda_oe <= 1'b0;
                            state  <= S_BYTE1;
                        end
                        S_BYTE1: if (byte_done) begin
                            cnt    <= '0;
                            reg_q  <= sh[7:1];
                            d8     <= sh[0];
                            sda_oe <= 1'b1;
                            state  <= S_ACK_1;
                        end
                        S_ACK_1: begin
                            sda_oe <= 1'b0;
                            state  <= S_BYTE2;
                        end
                        S_BYTE2: if (byte_done) begin
                            cnt <= '0;
                            if (commit) begin
                                sda_oe  <= 1'b1;
                                wr_en   <= 1'b1;
                                wr_addr <= reg_q;
                                wr_data <= {d8, sh};
                                state   <= S_ACK_2;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                        S_ACK_2: begin
                            sda_oe <= 1'b0;
                            state  <= S_IGNORE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
